// File: rtl/cu_seq_pkg.sv
// cu_seq_pkg: shared state encoding and interrupt-entry control constants for cu_sequencer
package cu_seq_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_INTER} seq_state_t;
  localparam logic [1:0] PC_MUX_ISR     = 2'b10;
  localparam logic [1:0] SCR_ADDR_SP_M1 = 2'b11;
  localparam logic       SCR_DATA_PC    = 1'b1;
endpackage

// File: rtl/cu_int_sync.sv
// cu_int_sync: multi-flop synchroniser for the raw interrupt line plus rising-edge detector
module cu_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_out
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], async_in};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end
  assign edge_out = sync[SYNC_STAGES-1] & ~sync_d;
endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: INIT/FETCH/EXEC/INTER sequencer owning the I flag and interrupt pending latch
module cu_sequencer
  import cu_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int INIT_CYCLES = 1
) (
  input  logic       SEQ_CLK,
  input  logic       SEQ_RST_N,
  input  logic       SEQ_INT,
  input  logic       SEQ_DEC_I_SET,
  input  logic       SEQ_DEC_I_CLR,
  output logic       SEQ_RST_OUT,
  output logic       SEQ_IR_LD,
  output logic       SEQ_PC_INC,
  output logic       SEQ_EXEC_EN,
  output logic       SEQ_INT_FLG_SHAD_LD,
  output logic       SEQ_INT_PC_LD,
  output logic [1:0] SEQ_INT_PC_MUX_SEL,
  output logic       SEQ_INT_SP_DECR,
  output logic       SEQ_INT_SCR_WE,
  output logic       SEQ_INT_SCR_DATA_SEL,
  output logic [1:0] SEQ_INT_SCR_ADDR_SEL,
  output logic       SEQ_I_FLAG,
  output logic [1:0] SEQ_STATE
);
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  seq_state_t state, next_state;
  logic [3:0] init_cnt;
  logic       i_flag, pending, int_edge;
  cu_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (SEQ_CLK),
    .rst_n    (SEQ_RST_N),
    .async_in (SEQ_INT),
    .edge_out (int_edge)
  );
  always_ff @(posedge SEQ_CLK or negedge SEQ_RST_N) begin
    if (!SEQ_RST_N) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      i_flag   <= 1'b0;
      pending  <= 1'b0;
    end else begin
      state    <= next_state;
      init_cnt <= (state == ST_INIT) ? init_cnt + 4'd1 : init_cnt;
      i_flag   <= (state == ST_INTER) ? 1'b0 :
                  (state != ST_EXEC) ? i_flag :
                  SEQ_DEC_I_CLR ? 1'b0 : SEQ_DEC_I_SET ? 1'b1 : i_flag;
      // a new edge beats the INTER clear so back-to-back requests are not lost
      pending  <= (int_edge && i_flag) ? 1'b1 : (state == ST_INTER) ? 1'b0 : pending;
    end
  end
  always_comb begin
    next_state = ST_FETCH;
    case (state)
      ST_INIT:  next_state = (init_cnt == INIT_LAST) ? ST_FETCH : ST_INIT;
      ST_FETCH: next_state = ST_EXEC;
      ST_EXEC:  next_state = (pending && i_flag) ? ST_INTER : ST_FETCH;
      default:  next_state = ST_FETCH;
    endcase
  end
  always_comb begin
    SEQ_RST_OUT          = state == ST_INIT;
    SEQ_IR_LD            = state == ST_FETCH;
    SEQ_PC_INC           = state == ST_FETCH;
    SEQ_EXEC_EN          = state == ST_EXEC;
    SEQ_INT_FLG_SHAD_LD  = state == ST_INTER;
    SEQ_INT_PC_LD        = state == ST_INTER;
    SEQ_INT_PC_MUX_SEL   = (state == ST_INTER) ? PC_MUX_ISR : 2'b00;
    SEQ_INT_SP_DECR      = state == ST_INTER;
    SEQ_INT_SCR_WE       = state == ST_INTER;
    SEQ_INT_SCR_DATA_SEL = (state == ST_INTER) ? SCR_DATA_PC : 1'b0;
    SEQ_INT_SCR_ADDR_SEL = (state == ST_INTER) ? SCR_ADDR_SP_M1 : 2'b00;
    SEQ_I_FLAG           = i_flag;
    SEQ_STATE            = state;
  end
endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
Fetch/execute/interrupt sequencer that sits directly upstream of the combinational opcode decoder in the RAT CPU.
- Steps the CPU through INIT, FETCH, EXEC and INTER phases.
- Owns the interrupt-enable (I) flag and the interrupt pending latch.
- Qualifies the decoder: the top level ANDs every decoder output with SEQ_EXEC_EN, then ORs in this block's INTER-state control bundle.

Parameters:
SYNC_STAGES, 2, number of flops in the SEQ_INT synchroniser (legal 2..4).
INIT_CYCLES, 1, cycles SEQ_RST_OUT is held after reset release (legal 1..15).

Ports:
SEQ_CLK  input  1  system clock, rising edge.
SEQ_RST_N  input  1  reset, asynchronous, active-low.
SEQ_INT  input  1  raw external interrupt request, asynchronous to SEQ_CLK.
SEQ_DEC_I_SET  input  1  decoder SEI/RETIE request; honoured only in EXEC.
SEQ_DEC_I_CLR  input  1  decoder CLI/RETID request; honoured only in EXEC.
SEQ_RST_OUT  output  1  synchronous reset to PC, SP and flags.
SEQ_IR_LD  output  1  load the instruction register from program ROM.
SEQ_PC_INC  output  1  increment PC.
SEQ_EXEC_EN  output  1  decoder output enable.
SEQ_INT_FLG_SHAD_LD  output  1  copy C/Z into the shadow flags.
SEQ_INT_PC_LD  output  1  load PC.
SEQ_INT_PC_MUX_SEL  output  2  PC mux select.
SEQ_INT_SP_DECR  output  1  SP decrement.
SEQ_INT_SCR_WE  output  1  scratch RAM write enable.
SEQ_INT_SCR_DATA_SEL  output  1  scratch data select; 1 = PC.
SEQ_INT_SCR_ADDR_SEL  output  2  scratch address select.
SEQ_I_FLAG  output  1  current interrupt-enable flag.
SEQ_STATE  output  2  state encoding, for debug.

Behaviour:
- State encoding: INIT=00, FETCH=01, EXEC=10, INTER=11.
- Asynchronous reset (SEQ_RST_N=0):
  - state = INIT, init counter = 0, I flag = 0, pending = 0, synchroniser and edge flops = 0.
  - Outputs follow from INIT: SEQ_RST_OUT = 1, every other output = 0, SEQ_STATE = 00.
- All outputs are Moore, decoded from state, except SEQ_I_FLAG, which is the I register.
- INIT:
  - SEQ_RST_OUT = 1; init counter increments each cycle.
  - Go to FETCH when counter == INIT_CYCLES-1. INIT therefore lasts exactly INIT_CYCLES cycles after reset release.
- FETCH: SEQ_IR_LD = 1, SEQ_PC_INC = 1, for one cycle. Always go to EXEC.
- EXEC:
  - SEQ_EXEC_EN = 1 for one cycle.
  - Go to INTER if pending == 1 AND I == 1, using the register values at the start of the cycle; otherwise go to FETCH.
  - Consequence: an SEI executing in this cycle cannot trigger INTER at the end of the same instruction.
- INTER:
  - For one cycle drive SEQ_INT_FLG_SHAD_LD = 1, SEQ_INT_PC_LD = 1, SEQ_INT_PC_MUX_SEL = 2'b10, SEQ_INT_SP_DECR = 1, SEQ_INT_SCR_WE = 1, SEQ_INT_SCR_DATA_SEL = 1, SEQ_INT_SCR_ADDR_SEL = 2'b11.
  - Clear I and pending. Always go to FETCH.
- I flag updates at the clock edge:
  - Cleared in INTER.
  - In EXEC, cleared by DEC_I_CLR, else set by DEC_I_SET. If both are asserted, clear wins.
  - DEC_I_SET / DEC_I_CLR are ignored in all states other than EXEC.
- Interrupt path:
  - SEQ_INT passes through SYNC_STAGES flops, then a rising-edge detector (synced & ~synced_d).
  - An edge sets pending only if I == 1. Edges arriving while I == 0 are dropped.
  - A level held high produces only one edge.
  - If an edge and the INTER clear occur in the same cycle, set wins and pending stays 1.
  - Latency: a SEQ_INT rise reaches pending after SYNC_STAGES+1 edges.
- Steady-state instruction period is 2 cycles; an interrupt adds 1 cycle (INTER).
- Reset asserted mid-operation, in any state, returns the block to INIT immediately and asynchronously.

Decomposition:
- Package cu_seq_pkg:
  - typedef enum logic [1:0] seq_state_t {ST_INIT, ST_FETCH, ST_EXEC, ST_INTER}.
  - Constants PC_MUX_ISR = 2'b10, SCR_ADDR_SP_M1 = 2'b11, SCR_DATA_PC = 1'b1.
- Sub-module cu_int_sync:
  - Parameterised SYNC_STAGES synchroniser plus edge detector.
  - Ports: clk, rst_n, async_in, edge_out.

Test Plan:
1. Reset with INIT_CYCLES=3, SEQ_INT=0 → SEQ_RST_OUT high for 3 cycles after SEQ_RST_N rises. SEQ_STATE then cycles 01,10,01,10. SEQ_IR_LD and SEQ_EXEC_EN alternate.
2. Pulse SEQ_DEC_I_SET during EXEC, then raise SEQ_INT for 1 cycle → SEQ_I_FLAG=1. Within ≤2 instructions, SEQ_STATE=11 for exactly 1 cycle, following an EXEC cycle. In that cycle SEQ_INT_PC_MUX_SEL=10, SEQ_INT_SCR_ADDR_SEL=11, SEQ_INT_SP_DECR=1. SEQ_I_FLAG=0 afterwards.
3. I=0 when SEQ_INT pulses, then SEI → no INTER occurs; the dropped edge must not fire later.
4. SEQ_DEC_I_SET=1 and SEQ_DEC_I_CLR=1 together in EXEC → SEQ_I_FLAG=0. Same pair asserted in FETCH → SEQ_I_FLAG unchanged.
5. SEQ_INT held high for 20 cycles with I=1, with RETIE-style SEI re-enabling after the ISR → exactly one INTER.
6. Assert SEQ_RST_N=0 during INTER → SEQ_INT_* outputs drop to 0 and SEQ_RST_OUT rises within the same cycle, asynchronously. SEQ_I_FLAG=0 and pending=0.
